// File: rtl/pool_row_feeder.sv
// Raster-to-row-pair front end for the 2x2 max-pool stage: buffers even rows,
// streams aligned (even, odd) pixel pairs during odd rows and tracks pool results.
module pool_row_feeder #(
  parameter int BIT_WIDTH = 32,
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28,
  parameter int COL_BITS  = $clog2(IN_WIDTH),
  parameter int ROW_BITS  = $clog2(IN_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  output logic                        out_en,
  output logic signed [BIT_WIDTH-1:0] out_row1,
  output logic signed [BIT_WIDTH-1:0] out_row2,
  output logic                        pool_valid,
  output logic [COL_BITS-2:0]         pool_x,
  output logic [ROW_BITS-2:0]         pool_y,
  output logic                        frame_done
);

  if ((IN_WIDTH % 2) != 0 || (IN_HEIGHT % 2) != 0 || IN_WIDTH < 2 || IN_HEIGHT < 2) begin : g_bad_cfg
    $fatal(1, "pool_row_feeder: IN_WIDTH and IN_HEIGHT must be even and >= 2");
  end

  logic [COL_BITS-1:0]         col;
  logic [ROW_BITS-1:0]         row;
  logic signed [BIT_WIDTH-1:0] linebuf [IN_WIDTH];

  // Attributes of the pixel behind the current out_en cycle.
  logic                        odd_col_q;
  logic                        last_q;
  logic [COL_BITS-2:0]         px_q;
  logic [ROW_BITS-2:0]         py_q;

  logic col_last;
  logic row_last;

  always_comb begin
    col_last = (col == COL_BITS'(IN_WIDTH - 1));
    row_last = (row == ROW_BITS'(IN_HEIGHT - 1));
  end

  // Line buffer has no reset; even rows only write, odd rows only read.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && !row[0]) begin
      linebuf[col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_en     <= 1'b0;
      out_row1   <= '0;
      out_row2   <= '0;
      pool_valid <= 1'b0;
      pool_x     <= '0;
      pool_y     <= '0;
      frame_done <= 1'b0;
      odd_col_q  <= 1'b0;
      last_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      out_en     <= 1'b0;
      // The pool latches the odd-column pair on this edge, so its result is complete next cycle.
      pool_valid <= out_en && odd_col_q;
      frame_done <= out_en && odd_col_q && last_q;
      if (out_en && odd_col_q) begin
        pool_x <= px_q;
        pool_y <= py_q;
      end

      if (in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (row[0]) begin
          out_en    <= 1'b1;
          out_row1  <= linebuf[col];
          out_row2  <= in_data;
          odd_col_q <= col[0];
          last_q    <= col_last && row_last;
          px_q      <= col[COL_BITS-1:1];
          py_q      <= row[ROW_BITS-1:1];
        end
      end
    end
  end

endmodule
